// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: multiply opcodes and multiply FSM states.
// Imported by the E-stage multiply sequencer, decoder and hazard unit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL   = 2'b00,
    MUL_OP_MLA   = 2'b01,
    MUL_OP_UMULL = 2'b10,
    MUL_OP_SMULL = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Magnitude of a two's-complement word; -2^31 maps to 0x80000000.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Operand/product datapath of the iterative multiplier.
// Ports: clk, reset, load (capture a/b, clear product), step (one
// partial-product add), a, b operands, product (64-bit accumulator).
module mul_shift_add #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
);

  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic [63:0] pp;

  // Multiplicand is pre-shifted each step, so the partial product
  // is just mcand times the next low-order multiplier digit.
  always_comb begin
    pp = mcand_q * 64'(mplier_q[BITS_PER_CYCLE-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (load) begin
      mcand_q  <= {32'b0, a};
      mplier_q <= b;
      prod_q   <= '0;
    end else if (step) begin
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      prod_q   <= prod_q + pp;
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// E-stage multiply sequencer: FSM, counter, sign fix-up, MLA add.
// Ports: clk, reset, StartMulE/MulOpE/SrcAE/SrcBE/SrcCE/KillE in;
// MulBusyE (stall), MulDoneE (pulse), MulResLoE/MulResHiE out.
module mul_seq_ctrl
  import pipeline_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartMulE,
  input  logic [1:0]  MulOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [31:0] SrcCE,
  input  logic        KillE,
  output logic        MulBusyE,
  output logic        MulDoneE,
  output logic [31:0] MulResLoE,
  output logic [31:0] MulResHiE
);

  localparam int N_ITER = 32 / BITS_PER_CYCLE;

  mul_state_e  state_q, state_d;
  logic [5:0]  count_q;
  mul_op_e     op_q;
  logic [31:0] srcc_q;
  logic        neg_q;
  logic [63:0] res_q;

  logic        load;
  logic        step;
  logic        is_smull;
  logic [31:0] a_ld;
  logic [31:0] b_ld;
  logic [63:0] prod;
  logic [63:0] fin;

  assign is_smull = (MulOpE == MUL_OP_SMULL);
  assign load = (state_q == MUL_IDLE) & StartMulE & ~KillE;
  assign step = (state_q == MUL_RUN);
  assign a_ld = is_smull ? abs32(SrcAE) : SrcAE;
  assign b_ld = is_smull ? abs32(SrcBE) : SrcBE;

  mul_shift_add #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .a      (a_ld),
    .b      (b_ld),
    .product(prod)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MUL_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      op_q    <= MUL_OP_MUL;
      srcc_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      if (load) begin
        count_q <= 6'(N_ITER);
        op_q    <= mul_op_e'(MulOpE);
        srcc_q  <= SrcCE;
        neg_q   <= is_smull & (SrcAE[31] ^ SrcBE[31]);
      end else if (step) begin
        count_q <= count_q - 6'd1;
      end
      if (MulDoneE) res_q <= fin;
    end
  end

  always_comb begin
    state_d  = state_q;
    MulBusyE = 1'b0;
    MulDoneE = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        MulBusyE = StartMulE & ~KillE;
        if (StartMulE) state_d = MUL_RUN;
      end
      MUL_RUN: begin
        MulBusyE = ~KillE;
        if (count_q == 6'd1) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        MulDoneE = ~KillE;
        state_d  = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
    // A flush wins over every transition.
    if (KillE) state_d = MUL_IDLE;
  end

  always_comb begin
    fin = prod;
    unique case (op_q)
      MUL_OP_MUL:   fin = {32'b0, prod[31:0]};
      MUL_OP_MLA:   fin = {32'b0, prod[31:0] + srcc_q};
      MUL_OP_UMULL: fin = prod;
      MUL_OP_SMULL: fin = neg_q ? -prod : prod;
      default:      fin = prod;
    endcase
  end

  // The live result is shown during DONE, the held copy otherwise.
  assign {MulResHiE, MulResLoE} = MulDoneE ? fin : res_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed and random multiplies checked
// against an arithmetic reference, at 2 and 1 bits per cycle.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, kill, sel;
  logic [1:0]  op;
  logic [31:0] a, b, c;

  logic        start0, start1;
  logic        busy0, done0, busy1, done1;
  logic [31:0] lo0, hi0, lo1, hi1;
  logic        busy, done;
  logic [63:0] res;
  logic [63:0] last;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign res  = sel ? {hi1, lo1} : {hi0, lo0};

  mul_seq_ctrl #(.BITS_PER_CYCLE(2)) dut0 (
    .clk(clk), .reset(reset), .StartMulE(start0), .MulOpE(op),
    .SrcAE(a), .SrcBE(b), .SrcCE(c), .KillE(kill),
    .MulBusyE(busy0), .MulDoneE(done0),
    .MulResLoE(lo0), .MulResHiE(hi0)
  );

  mul_seq_ctrl #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .StartMulE(start1), .MulOpE(op),
    .SrcAE(a), .SrcBE(b), .SrcCE(c), .KillE(1'b0),
    .MulBusyE(busy1), .MulDoneE(done1),
    .MulResLoE(lo1), .MulResHiE(hi1)
  );

  function automatic logic [63:0] model(input logic [1:0] o,
    input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [63:0] ux, uy, sx, sy, p;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'd0:    p = {32'b0, x * y};
      2'd1:    p = {32'b0, x * y + z};
      2'd2:    p = ux * uy;
      default: p = sx * sy;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
    input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input string tag, input logic [1:0] o,
    input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
    input int exp_busy);
    int nb;
    bit seen;
    logic [63:0] e;
    e = model(o, x, y, z);
    op = o; a = x; b = y; c = z;
    start = 1'b1;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({tag, "_donebusy"}, 64'(busy), 64'd0);
        chk({tag, "_res"}, res, e);
      end else if (busy) begin
        nb++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_stall"}, 64'(nb), 64'(exp_busy));
    last = e;
  endtask

  task automatic idle_chk(input string tag, input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, res, last);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; sel = 1'b0;
    op = 2'd0; a = '0; b = '0; c = '0; last = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_res", {hi0, lo0}, 64'd0);
    chk("rst_res1", {hi1, lo1}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("umull_max", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 17);
    idle_chk("post_umull", 2);
    run_op("smull_neg", 2'd3, 32'hFFFFFFFD, 32'd7, 0, 17);
    chk("smull_neg_k", last, 64'hFFFFFFFF_FFFFFFEB);
    run_op("smull_min", 2'd3, 32'h80000000, 32'h80000000, 0, 17);
    chk("smull_min_k", last, 64'h40000000_00000000);
    run_op("mla_wrap", 2'd1, 32'd5, 32'd6, 32'hFFFFFFF0, 17);
    chk("mla_wrap_k", last, 64'h0000000E);
    run_op("mul_ovf", 2'd0, 32'h10000, 32'h10000, 0, 17);
    idle_chk("post_mul", 1);

    // Flush in the fifth RUN cycle.
    op = 2'd2; a = 32'hDEADBEEF; b = 32'h12345678; c = '0;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    kill = 1'b1;
    @(negedge clk);
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_done", 64'(done), 64'd0);
    chk("kill_res", res, last);
    @(posedge clk); #1;
    kill = 1'b0;
    idle_chk("post_kill", 20);

    // Back-to-back: second start the cycle after DONE.
    run_op("b2b_a", 2'd0, 32'd3, 32'd4, 0, 17);
    run_op("b2b_b", 2'd0, 32'd5, 32'd6, 0, 17);
    chk("b2b_k", last, 64'd30);
    idle_chk("post_b2b", 1);

    for (int i = 0; i < 12; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 3));
      run_op("rand", ro, $urandom, $urandom, $urandom, 17);
      if ($urandom_range(0, 1) == 1) idle_chk("rand_gap", 1);
    end

    // Reset in the middle of RUN.
    op = 2'd2; a = 32'hCAFEF00D; b = 32'h0BADBEEF;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_res", res, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last = '0;
    idle_chk("post_mrst", 2);

    sel = 1'b1;
    idle_chk("bpc1_idle", 1);
    run_op("bpc1", 2'd2, 32'h12345678, 32'h9ABCDEF0, 0, 33);
    chk("bpc1_k", last, 64'h0B00EA4E_242D2080);
    run_op("bpc1_s", 2'd3, $urandom, $urandom, 0, 33);
    run_op("bpc1_m", 2'd1, $urandom, $urandom, $urandom, 33);
    idle_chk("bpc1_post", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      ncmp, nfail);
    $finish;
  end

endmodule
